mul_seq_ctl: RTL and testbench
==============================

Name: mul_seq_ctl

Overview:
- Iterative multiplier sequencer; shares one carry-save partial-product row among WIDTH/STEP cycles instead of a full array.
- Built from the existing full-adder/half-adder cells (mulgen_FA, mulgen_HA).
- Sits beside the integer ALU. Accepts one multiply per handshake and returns the full 2*WIDTH product with its tag.
- Supports flush (kill) of an in-flight operation.

Parameters:
- WIDTH, 64, operand width; must be a multiple of STEP.
- STEP, 4, multiplier bits consumed per RUN cycle.
- TAG_W, 9, width of the opaque tag carried with each operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_a_sgn  in  1  in_a is two's-complement signed.
- in_b_sgn  in  1  in_b is two's-complement signed.
- in_tag  in  TAG_W  tag returned with the result.
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_res  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the product.
- busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, RUN, FINAL, DONE. Reset: state=IDLE, counter=0, out_valid=0, out_res=0, out_tag=0, busy=0, CSA sum/carry=0. in_ready=0 while rst is high.
- in_ready = ~rst & ~flush & (IDLE | (DONE & out_ready)). Accept = in_valid & in_ready.
- Accept latches a, b, signs and tag, clears sum/carry and counter, and goes to RUN.
- RUN:
  - Each cycle adds the partial products of the next STEP bits of b, LSB first, into the carry-save accumulator.
  - Shifts the b register by STEP and increments the counter.
  - After WIDTH/STEP RUN cycles the next state is FINAL.
- FINAL (1 cycle): carry-propagate adds sum+carry into out_res, loads out_tag, goes to DONE.
- DONE: out_valid=1; out_res and out_tag are held stable until out_ready.
  - out_ready with no accept: go to IDLE, out_valid=0.
  - out_ready with accept in the same cycle: go directly to RUN (back-to-back).
- Latency: out_valid is first high WIDTH/STEP+2 cycles after the accept cycle (18 for the defaults). Throughput: one result per WIDTH/STEP+2 cycles.
- Arithmetic: out_res is the exact 2*WIDTH-bit product of the operands, each interpreted per its sign bit.
  - in_a_sgn: in_a is sign-extended to 2*WIDTH bits inside the partial products.
  - in_b_sgn: bit WIDTH-1 of b carries weight -2^(WIDTH-1), realised in the last RUN step by inverting that partial product and injecting +1 at its LSB.
  - Modulo 2^(2*WIDTH); no overflow flag.
- flush: in RUN, FINAL or DONE, the next state is IDLE and out_valid=0 next cycle. The result is discarded; out_res and out_tag keep their old values.
  - flush while IDLE: no effect; no accept that cycle.
  - flush in the same cycle as out_ready in DONE: flush wins; no handshake is counted.
- rst asserted mid-operation: immediately forces reset values; no partial result is ever presented.
- in_valid must stay high with stable data until accepted; in_* are sampled only on accept.

Optional Feature:
- Macro: MUL_EARLY_OUT_EN.
- Defined: at the end of each RUN cycle, if the remaining unprocessed b bits are all zero, the next state is FINAL.
  - Applies when b is unsigned, or when b is signed and non-negative.
  - Minimum latency is 3 cycles (b=0: one RUN, FINAL, DONE).
  - A negative signed b never early-outs.
  - out_res is identical to the non-early result.
- Undefined: fixed latency WIDTH/STEP+2 regardless of operand values; the early-out logic is absent.

Decomposition:
- Package mul_seq_pkg:
  - state enum (IDLE/RUN/FINAL/DONE);
  - STEPS = WIDTH/STEP;
  - CNT_W = clog2(STEPS+1);
  - result width constant 2*WIDTH.
- Sub-module mul_seq_csa_row: combinational compressor built from mulgen_FA/mulgen_HA. It compresses STEP shifted, optionally inverted partial products plus the incoming sum/carry into a new sum/carry pair.
- The FSM, registers and carry-propagate adder live in mul_seq_ctl.

Test Plan:
- Unsigned: a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF, tag=0x1A5 -> out_res=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, out_tag=0x1A5, out_valid at accept+18 (macro off).
- Signed: a=-3, b=7 with both signs set -> out_res=-21 (0xFFFF…FFEB). a=-2^63, b=-1 signed -> out_res=2^63.
- Back-to-back with out_ready held high: ops (5*6, tag 1) then (7*8, tag 2) -> results 30 then 56 with correct tags. The second op is accepted in the DONE cycle of the first.
- Backpressure then flush: out_ready=0 for 5 cycles holds out_res and out_tag stable. A flush during RUN cycle 8 -> no out_valid; in_ready=1 the next cycle.
- Reset in FINAL -> out_valid=0, out_res=0, state IDLE. A subsequent op 3*4 -> out_res=12.
- MUL_EARLY_OUT_EN: b=0x3, a=0x10 -> out_res=0x30, out_valid at accept+3; signed b=-1 -> full latency of 18.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared constants and state encoding for the iterative multiplier sequencer.
// Optional early-out is controlled by MUL_EARLY_OUT_EN in mul_seq_ctl.
package mul_seq_pkg;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_STEP  = 4;
  localparam int MUL_TAG_W = 9;
  localparam int MUL_STEPS = MUL_WIDTH / MUL_STEP;
  localparam int MUL_CNT_W = $clog2(MUL_STEPS + 1);
  localparam int MUL_RES_W = 2 * MUL_WIDTH;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_FINAL = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  function automatic int cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/mul_seq_csa_row.sv
// Combinational carry-save compressor: folds STEP shifted partial products of
// i_a into the running sum/carry pair; the last one may be negated (~pp + 1).
module mul_seq_csa_row #(
  parameter int RES_W = 128,
  parameter int STEP  = 4
) (
  input  logic [RES_W-1:0] i_a,
  input  logic [STEP-1:0]  i_b_bits,
  input  logic             i_neg,
  input  logic [RES_W-1:0] i_sum,
  input  logic [RES_W-1:0] i_carry,
  output logic [RES_W-1:0] o_sum,
  output logic [RES_W-1:0] o_carry
);

  logic [STEP:0][RES_W-1:0]   w_s;
  logic [STEP-1:0][RES_W-2:0] w_cu;

  assign w_s[0] = i_sum;

  // w_cu[j][i] carries weight 2^(i+1); inner rows have no carry at bit 0, so a
  // half adder suffices there. The +1 of the negation fills that free slot.
  for (genvar j = 0; j < STEP; j++) begin : g_row
    logic [RES_W-1:0] w_pp;
    assign w_pp = (i_b_bits[j] ? (i_a << j) : '0) ^ {RES_W{i_neg && (j == STEP-1)}};

    for (genvar i = 0; i < RES_W-1; i++) begin : g_bit
      if (j == 0) begin : g_fa0
        mulgen_FA u_fa (.a(w_s[0][i]), .b(i_carry[i]), .ci(w_pp[i]),
                        .s(w_s[1][i]), .co(w_cu[0][i]));
      end else if (i == 0) begin : g_ha
        mulgen_HA u_ha (.a(w_s[j][0]), .b(w_pp[0]),
                        .s(w_s[j+1][0]), .co(w_cu[j][0]));
      end else begin : g_fa
        mulgen_FA u_fa (.a(w_s[j][i]), .b(w_cu[j-1][i-1]), .ci(w_pp[i]),
                        .s(w_s[j+1][i]), .co(w_cu[j][i]));
      end
    end

    if (j == 0) begin : g_top0
      assign w_s[1][RES_W-1] = w_s[0][RES_W-1] ^ i_carry[RES_W-1] ^ w_pp[RES_W-1];
    end else begin : g_top
      assign w_s[j+1][RES_W-1] = w_s[j][RES_W-1] ^ w_cu[j-1][RES_W-2] ^ w_pp[RES_W-1];
    end
  end

  assign o_sum   = w_s[STEP];
  assign o_carry = {w_cu[STEP-1], i_neg};

endmodule

// File: rtl/mulgen_cells.sv
// Single-bit adder cells shared by the multiplier generators.
module mulgen_FA (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module mulgen_HA (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

// File: rtl/mul_seq_ctl.sv
// Iterative signed/unsigned multiplier sequencer with tag, flush and handshake.
// Define MUL_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; in_* must be held stable while in_valid waits, out_res/out_tag are held
// while out_valid waits for out_ready. flush overrides any output handshake.
module mul_seq_ctl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int STEP  = MUL_STEP,
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_a_sgn,
  input  logic               in_b_sgn,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_res,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy,
  output state_t             dbg_state
);

  localparam int STEPS = WIDTH / STEP;
  localparam int CNT_W = cnt_width(STEPS);
  localparam int RES_W = 2 * WIDTH;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RES_W-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b;
  logic               r_b_sgn;
  logic [TAG_W-1:0]   r_tag;
  logic [RES_W-1:0]   r_sum;
  logic [RES_W-1:0]   r_carry;
  logic [RES_W-1:0]   r_out_res;
  logic [TAG_W-1:0]   r_out_tag;

  logic               w_accept;
  logic               w_last_step;
  logic               w_run_end;
  logic               w_neg;
  logic [RES_W-1:0]   w_sum_nxt;
  logic [RES_W-1:0]   w_carry_nxt;

  assign in_ready = ~rst & ~flush &
                    ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

  assign w_last_step = (r_cnt == CNT_W'(STEPS - 1));
  assign w_neg       = r_b_sgn & w_last_step;

`ifdef MUL_EARLY_OUT_EN
  // A negative signed b keeps its MSB in the unprocessed bits until the last step.
  assign w_run_end = w_last_step | (r_b[WIDTH-1:STEP] == '0);
`else
  assign w_run_end = w_last_step;
`endif

  mul_seq_csa_row #(
    .RES_W(RES_W),
    .STEP (STEP)
  ) u_row (
    .i_a     (r_a_sh),
    .i_b_bits(r_b[STEP-1:0]),
    .i_neg   (w_neg),
    .i_sum   (r_sum),
    .i_carry (r_carry),
    .o_sum   (w_sum_nxt),
    .o_carry (w_carry_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a_sh    <= '0;
      r_b       <= '0;
      r_b_sgn   <= 1'b0;
      r_tag     <= '0;
      r_sum     <= '0;
      r_carry   <= '0;
      r_out_res <= '0;
      r_out_tag <= '0;
    end else if (w_accept) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_a_sh  <= {{WIDTH{in_a_sgn & in_a[WIDTH-1]}}, in_a};
      r_b     <= in_b;
      r_b_sgn <= in_b_sgn;
      r_tag   <= in_tag;
      r_sum   <= '0;
      r_carry <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
            r_a_sh  <= r_a_sh << STEP;
            r_b     <= r_b >> STEP;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_run_end) r_state <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_out_res <= r_sum + r_carry;
            r_out_tag <= r_tag;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign out_res   = r_out_res;
  assign out_tag   = r_out_tag;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_seq_ctl.sv
// Self-checking bench for mul_seq_ctl: directed, back-to-back, backpressure,
// flush, reset and randomized operations against an arithmetic reference.
module tb_mul_seq_ctl;
  localparam int W    = 64;
  localparam int STEP = 4;
  localparam int TW   = 9;
  localparam int RW   = 2 * W;
`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_a_sgn;
  logic          in_b_sgn;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_res;
  logic [TW-1:0] out_tag;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0] exp_q[$];
  logic [TW-1:0] tag_q[$];
  int            lat_q[$];

  mul_seq_ctl #(.WIDTH(W), .STEP(STEP), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_a_sgn (in_a_sgn),
    .in_b_sgn (in_b_sgn),
    .in_tag   (in_tag),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_tag  (out_tag),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic as, input logic bs);
    logic [RW-1:0] ae;
    logic [RW-1:0] be;
    ae = {{W{as & a[W-1]}}, a};
    be = {{W{bs & b[W-1]}}, b};
    return ae * be;
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle.
  function automatic int ref_lat(input logic [W-1:0] b, input logic bs);
    int steps;
    steps = 1;
    for (int k = 0; k < W; k++) if (b[k]) steps = k / STEP + 1;
    if (EARLY && !(bs && b[W-1])) return steps + 2;
    return W / STEP + 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic as, input logic bs, input logic [TW-1:0] tag);
    in_a     = a;
    in_b     = b;
    in_a_sgn = as;
    in_b_sgn = bs;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int k;
    k = 0;
    while (!in_ready && k < 64) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s accept_timeout: in_ready=%b required 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Called in the cycle right after the accept; returns that cycle's index.
  task automatic wait_valid(input string name, output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s valid_timeout: out_valid=%b required 1", name, out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_a_sgn = 1'b0; in_b_sgn = 1'b0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_res !== '0) begin n_errors++; $display("FAIL reset_out_res: got %h want 0", out_res); end
    n_checks++;
    if (out_tag !== '0) begin n_errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0]  da[3];
    logic [W-1:0]  db[3];
    logic          ds[3];
    logic [TW-1:0] dt[3];
    logic [RW-1:0] exp;
    logic [RW-1:0] lit;
    int lat;
    da[0] = 64'hFFFF_FFFF_FFFF_FFFF; db[0] = 64'hFFFF_FFFF_FFFF_FFFF; ds[0] = 1'b0; dt[0] = 9'h1A5;
    da[1] = -64'sd3;                 db[1] = 64'd7;                  ds[1] = 1'b1; dt[1] = 9'h0C3;
    da[2] = 64'h8000_0000_0000_0000; db[2] = 64'hFFFF_FFFF_FFFF_FFFF; ds[2] = 1'b1; dt[2] = 9'h17E;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = ref_mul(da[i], db[i], ds[i], ds[i]);
      drive_op(da[i], db[i], ds[i], ds[i], dt[i]);
      wait_accept("directed");
      wait_valid("directed", lat);
      n_checks++;
      if (out_res !== exp) begin n_errors++; $display("FAIL dir_res[%0d]: got %h want %h", i, out_res, exp); end
      n_checks++;
      if (out_tag !== dt[i]) begin n_errors++; $display("FAIL dir_tag[%0d]: got %h want %h", i, out_tag, dt[i]); end
      n_checks++;
      if (lat != ref_lat(db[i], ds[i])) begin
        n_errors++; $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, ref_lat(db[i], ds[i]));
      end
      if (i == 0) begin
        lit = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        n_checks++;
        if (out_res !== lit) begin n_errors++; $display("FAIL dir_umax_literal: got %h want %h", out_res, lit); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    drive_op(64'd5, 64'd6, 1'b0, 1'b0, 9'd1);
    wait_accept("b2b_first");
    drive_op(64'd7, 64'd8, 1'b0, 1'b0, 9'd2);
    wait_valid("b2b_first", lat);
    n_checks++;
    if (out_res !== 128'd30) begin n_errors++; $display("FAIL b2b_res1: got %h want 30", out_res); end
    n_checks++;
    if (out_tag !== 9'd1) begin n_errors++; $display("FAIL b2b_tag1: got %h want 1", out_tag); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_in_done: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL b2b_second_running: out_valid=%b busy=%b want 0 1", out_valid, busy);
    end
    wait_valid("b2b_second", lat);
    n_checks++;
    if (out_res !== 128'd56) begin n_errors++; $display("FAIL b2b_res2: got %h want 56", out_res); end
    n_checks++;
    if (out_tag !== 9'd2) begin n_errors++; $display("FAIL b2b_tag2: got %h want 2", out_tag); end
    n_checks++;
    if (lat != ref_lat(64'd8, 1'b0)) begin
      n_errors++; $display("FAIL b2b_lat2: got %0d want %0d", lat, ref_lat(64'd8, 1'b0));
    end
    tick();
  endtask

  task automatic test_backpressure_flush();
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] exp;
    logic          seen;
    int lat;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp = ref_mul(a, b, 1'b1, 1'b0);
    out_ready = 1'b0;
    drive_op(a, b, 1'b1, 1'b0, 9'h0A7);
    wait_accept("bp");
    wait_valid("bp", lat);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_res !== exp || out_tag !== 9'h0A7) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: valid=%b res=%h tag=%h want 1 %h 0a7", k, out_valid, out_res, out_tag, exp);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release: out_valid=%b want 0", out_valid); end

    // Flush during the eighth RUN cycle of a full-length operation.
    drive_op({$urandom, $urandom}, {1'b1, 31'($urandom), $urandom}, 1'b0, 1'b0, 9'h055);
    wait_accept("flush_run");
    for (int k = 1; k < 8; k++) tick();
    flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready_low: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL flush_run_idle: valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    n_checks++;
    if (out_res !== exp || out_tag !== 9'h0A7) begin
      n_errors++; $display("FAIL flush_keeps_out: res=%h tag=%h want %h 0a7", out_res, out_tag, exp);
    end
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      seen = seen | out_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL flush_no_result: out_valid seen=%b want 0", seen); end

    // Flush together with out_ready and a new offer while in DONE.
    drive_op(64'd9, 64'd9, 1'b0, 1'b0, 9'h011);
    wait_accept("flush_done");
    wait_valid("flush_done", lat);
    drive_op(64'd2, 64'd2, 1'b0, 1'b0, 9'h012);
    flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_done_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL flush_done_idle: valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_final();
    int lat;
    out_ready = 1'b1;
    drive_op({$urandom, $urandom}, {1'b1, 31'($urandom), $urandom}, 1'b0, 1'b0, 9'h0F0);
    wait_accept("rst_final");
    for (int k = 1; k < W / STEP + 1; k++) tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL rst_final_pre: valid=%b busy=%b want 0 1", out_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_res !== '0 || out_tag !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_final_values: valid=%b res=%h tag=%h busy=%b ready=%b want all 0",
               out_valid, out_res, out_tag, busy, in_ready);
    end
    tick();
    rst = 1'b0;
    drive_op(64'd3, 64'd4, 1'b0, 1'b0, 9'h033);
    wait_accept("rst_final_after");
    wait_valid("rst_final_after", lat);
    n_checks++;
    if (out_res !== 128'd12 || out_tag !== 9'h033) begin
      n_errors++; $display("FAIL rst_final_after: res=%h tag=%h want 12 033", out_res, out_tag);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          as;
    logic          bs;
    logic [TW-1:0] tag;
    logic [RW-1:0] exp;
    logic [TW-1:0] etag;
    int            elat;
    int            lat;
    int            stall;
    for (int n = 0; n < 40; n++) begin
      a   = {$urandom, $urandom} >> $urandom_range(0, 63);
      b   = {$urandom, $urandom} >> $urandom_range(0, 64);
      as  = 1'($urandom_range(0, 1));
      bs  = 1'($urandom_range(0, 1));
      tag = TW'($urandom);
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      exp_q.push_back(ref_mul(a, b, as, bs));
      tag_q.push_back(tag);
      lat_q.push_back(ref_lat(b, bs));
      out_ready = 1'b0;
      drive_op(a, b, as, bs, tag);
      wait_accept("rand");
      wait_valid("rand", lat);
      exp  = exp_q.pop_front();
      etag = tag_q.pop_front();
      elat = lat_q.pop_front();
      n_checks++;
      if (out_res !== exp) begin n_errors++; $display("FAIL rand_res[%0d]: got %h want %h", n, out_res, exp); end
      n_checks++;
      if (out_tag !== etag) begin n_errors++; $display("FAIL rand_tag[%0d]: got %h want %h", n, out_tag, etag); end
      n_checks++;
      if (lat != elat) begin n_errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, lat, elat); end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_res !== exp) begin
          n_errors++; $display("FAIL rand_stall[%0d]: valid=%b res=%h want 1 %h", n, out_valid, out_res, exp);
        end
      end
      out_ready = 1'b1;
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure_flush();
    test_reset_final();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
